// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//   Records up to 16 note codes into an external 16-entry RAM and plays them
//   back to a tone generator over a valid/ready handshake. Each presented
//   note is held for TICKS_PER_NOTE clock cycles after its handshake. Playback
//   either ends after the last note or, with loop_en, restarts from the first.
//
// Ports
//   clk         in   system clock, rising-edge active
//   reset       in   asynchronous active-low reset
//   load_n      in   active-low record key, falling edge records note_in
//   playback_n  in   active-low play key, falling edge starts playback
//   stop_n      in   active-low level abort of playback
//   loop_en     in   1 = restart from the first note after the last one
//   note_in     in   note code to record
//   mem_we      out  RAM write strobe
//   mem_addr    out  RAM address (write slot in IDLE/WRITE, play index otherwise)
//   mem_wdata   out  RAM write data
//   mem_rdata   in   RAM read data, valid one cycle after mem_addr
//   tone_note   out  note code to the tone generator, 0 = rest
//   tone_valid  out  handshake valid to the tone generator
//   tone_ready  in   handshake ready from the tone generator
//   note_count  out  number of stored notes, 0..16
//   playing     out  high in every playback state
// -----------------------------------------------------------------------------
module note_sequencer #(
    parameter int TICKS_PER_NOTE = 25000000,
    parameter int NOTE_W         = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_n,
    input  logic              playback_n,
    input  logic              stop_n,
    input  logic              loop_en,
    input  logic [NOTE_W-1:0] note_in,
    output logic              mem_we,
    output logic [3:0]        mem_addr,
    output logic [NOTE_W-1:0] mem_wdata,
    input  logic [NOTE_W-1:0] mem_rdata,
    output logic [NOTE_W-1:0] tone_note,
    output logic              tone_valid,
    input  logic              tone_ready,
    output logic [4:0]        note_count,
    output logic              playing
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_FETCH   = 3'd2,
        S_WAIT_RD = 3'd3,
        S_PRESENT = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    localparam logic [24:0] HOLD_LOAD = 25'(TICKS_PER_NOTE - 1);

    state_t            r_state;
    logic [4:0]        r_count;
    logic [3:0]        r_index;
    logic [24:0]       r_hold;
    logic [NOTE_W-1:0] r_tone_note;
    logic              r_tone_valid;
    logic              r_mem_we;
    logic [3:0]        r_mem_addr;
    logic [NOTE_W-1:0] r_mem_wdata;
    logic              r_playing;
    logic              r_load_d;
    logic              r_play_d;
    logic              r_armed;

    logic              w_load_edge;
    logic              w_play_edge;
    logic              w_in_play;
    logic              w_has_next;
    logic [4:0]        w_count_inc;

    // r_armed stays low for the first cycle after reset so that a key already
    // held down across reset release only loads its delay register and cannot
    // be mistaken for a fresh press.
    assign w_load_edge = r_armed & r_load_d & ~load_n;
    assign w_play_edge = r_armed & r_play_d & ~playback_n;
    assign w_in_play   = (r_state == S_FETCH) || (r_state == S_WAIT_RD) ||
                         (r_state == S_PRESENT) || (r_state == S_HOLD);
    // Another note follows when index+1 is still below the stored count.
    assign w_has_next  = (({1'b0, r_index}) + 5'd1) < r_count;
    assign w_count_inc = r_count + 5'd1;

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign tone_note  = r_tone_note;
    assign tone_valid = r_tone_valid;
    assign note_count = r_count;
    assign playing    = r_playing;

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_count      <= 5'd0;
            r_index      <= 4'd0;
            r_hold       <= 25'd0;
            r_tone_note  <= {NOTE_W{1'b0}};
            r_tone_valid <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 4'd0;
            r_mem_wdata  <= {NOTE_W{1'b0}};
            r_playing    <= 1'b0;
            r_load_d     <= 1'b1;
            r_play_d     <= 1'b1;
            r_armed      <= 1'b0;
        end else begin
            r_load_d <= load_n;
            r_play_d <= playback_n;
            r_armed  <= 1'b1;

            if (w_in_play && !stop_n) begin
                // Abort outranks every other playback transition.
                r_state      <= S_IDLE;
                r_tone_note  <= {NOTE_W{1'b0}};
                r_tone_valid <= 1'b0;
                r_playing    <= 1'b0;
                r_index      <= 4'd0;
                r_hold       <= 25'd0;
                r_mem_addr   <= r_count[3:0];
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Load is checked first so it wins a same-cycle tie.
                        if (w_load_edge && (r_count != 5'd16)) begin
                            r_state     <= S_WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_count[3:0];
                            r_mem_wdata <= note_in;
                        end else if (w_play_edge && (r_count != 5'd0)) begin
                            r_state    <= S_FETCH;
                            r_index    <= 4'd0;
                            r_mem_addr <= 4'd0;
                            r_playing  <= 1'b1;
                        end else begin
                            r_mem_addr <= r_count[3:0];
                        end
                    end
                    S_WRITE: begin
                        r_state    <= S_IDLE;
                        r_mem_we   <= 1'b0;
                        r_count    <= w_count_inc;
                        r_mem_addr <= w_count_inc[3:0];
                    end
                    S_FETCH: begin
                        // Address has been on the bus for this cycle.
                        r_state <= S_WAIT_RD;
                    end
                    S_WAIT_RD: begin
                        r_tone_note  <= mem_rdata;
                        r_tone_valid <= 1'b1;
                        r_state      <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (tone_ready) begin
                            r_tone_valid <= 1'b0;
                            r_hold       <= HOLD_LOAD;
                            r_state      <= S_HOLD;
                        end else begin
                            r_state <= S_PRESENT;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold == 25'd0) begin
                            if (w_has_next) begin
                                r_index    <= r_index + 4'd1;
                                r_mem_addr <= r_index + 4'd1;
                                r_state    <= S_FETCH;
                            end else if (loop_en) begin
                                r_index    <= 4'd0;
                                r_mem_addr <= 4'd0;
                                r_state    <= S_FETCH;
                            end else begin
                                r_tone_note <= {NOTE_W{1'b0}};
                                r_playing   <= 1'b0;
                                r_index     <= 4'd0;
                                r_mem_addr  <= r_count[3:0];
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_hold <= r_hold - 25'd1;
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_mem_we     <= 1'b0;
                        r_tone_valid <= 1'b0;
                        r_playing    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    localparam int TICKS = 4;
    localparam int NW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_n;
    logic          playback_n;
    logic          stop_n;
    logic          loop_en;
    logic [NW-1:0] note_in;
    logic          mem_we;
    logic [3:0]    mem_addr;
    logic [NW-1:0] mem_wdata;
    logic [NW-1:0] mem_rdata;
    logic [NW-1:0] tone_note;
    logic          tone_valid;
    logic          tone_ready;
    logic [4:0]    note_count;
    logic          playing;

    note_sequencer #(.TICKS_PER_NOTE(TICKS), .NOTE_W(NW)) dut (
        .clk(clk), .reset(reset), .load_n(load_n), .playback_n(playback_n),
        .stop_n(stop_n), .loop_en(loop_en), .note_in(note_in),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .tone_note(tone_note), .tone_valid(tone_valid),
        .tone_ready(tone_ready), .note_count(note_count), .playing(playing)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int inv_err = 0;

    // Synchronous-read note RAM: data appears one cycle after the address.
    logic [NW-1:0] ram [16];
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Logs of observed writes and tone handshakes, plus output invariants.
    logic [3:0]    wr_addr_q[$];
    logic [NW-1:0] wr_data_q[$];
    logic [NW-1:0] hs_q[$];
    int            hs_t[$];
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (tone_valid && tone_ready) begin
            hs_q.push_back(tone_note);
            hs_t.push_back(cyc);
        end
        if ((tone_valid && !playing) || (mem_we && playing) || (note_count > 5'd16))
            inv_err <= inv_err + 1;
    end

    typedef struct {
        bit            rst_before;
        logic [NW-1:0] note;
        bit            exp_we;
        logic [3:0]    exp_addr;
        logic [4:0]    exp_cnt;
    } ld_vec_t;
    ld_vec_t lv [20];

    logic [NW-1:0] m_notes[$];
    logic [NW-1:0] exp_seq [5];
    int base, hb, end_cyc, k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic press_load(input logic [NW-1:0] n);
        note_in = n;
        load_n  = 1'b0;
        tick();
        load_n  = 1'b1;
        tick();
        tick();
    endtask

    task automatic press_play();
        playback_n = 1'b0;
        tick();
        playback_n = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc, input bit rnd_ready);
        int n;
        n = 0;
        while (playing && n < max_cyc) begin
            tick();
            if (rnd_ready) tone_ready = 1'($urandom_range(0, 1));
            n++;
        end
        end_cyc = cyc;
        tone_ready = 1'b1;
        check("play_timeout", playing, 0);
    endtask

    task automatic wait_hs(input int target, input int max_cyc);
        int n;
        n = 0;
        while (hs_q.size() < target && n < max_cyc) begin
            tick();
            n++;
        end
        check("hs_timeout", (hs_q.size() >= target), 1);
    endtask

    task automatic apply_loads(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (lv[i].rst_before) do_reset();
            base = wr_addr_q.size();
            press_load(lv[i].note);
            check("ld_writes", wr_addr_q.size() - base, lv[i].exp_we);
            if (lv[i].exp_we && wr_addr_q.size() > base) begin
                check("ld_addr", wr_addr_q[base], lv[i].exp_addr);
                check("ld_data", wr_data_q[base], lv[i].note);
            end
            check("ld_count", note_count, lv[i].exp_cnt);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; load_n = 1'b1; playback_n = 1'b1; stop_n = 1'b1;
        loop_en = 1'b0; note_in = '0; tone_ready = 1'b1;

        lv[0] = '{rst_before: 1'b1, note: 5'd3, exp_we: 1'b1, exp_addr: 4'd0, exp_cnt: 5'd1};
        lv[1] = '{rst_before: 1'b0, note: 5'd7, exp_we: 1'b1, exp_addr: 4'd1, exp_cnt: 5'd2};
        lv[2] = '{rst_before: 1'b0, note: 5'd9, exp_we: 1'b1, exp_addr: 4'd2, exp_cnt: 5'd3};
        for (int i = 0; i < 17; i++)
            lv[3+i] = '{rst_before: (i == 0), note: 5'((i * 7 + 5) % 32), exp_we: (i < 16),
                        exp_addr: 4'(i % 16), exp_cnt: 5'((i < 16) ? (i + 1) : 16)};

        // Reset state, observed while reset is held.
        repeat (3) tick();
        check("rst_tone_note", tone_note, 0);
        check("rst_tone_valid", tone_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_playing", playing, 0);
        check("rst_count", note_count, 0);
        check("rst_addr", mem_addr, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Playback with nothing stored is ignored.
        press_play();
        tick();
        check("empty_play", playing, 0);

        // Record 3, 7, 9.
        apply_loads(0, 2);

        // Play once with ready tied high.
        loop_en = 1'b0; tone_ready = 1'b1;
        hb = hs_q.size();
        press_play();
        wait_idle(300, 1'b0);
        exp_seq = '{5'd3, 5'd7, 5'd9, 5'd3, 5'd7};
        check("a_hs_count", hs_q.size() - hb, 3);
        if (hs_q.size() >= hb + 3) begin
            for (int i = 0; i < 3; i++) check("a_note", hs_q[hb+i], exp_seq[i]);
            check("a_gap1", hs_t[hb+1] - hs_t[hb], TICKS + 3);
            check("a_gap2", hs_t[hb+2] - hs_t[hb+1], TICKS + 3);
            check("a_last_hold", end_cyc - hs_t[hb+2], TICKS + 1);
        end
        check("a_end_note", tone_note, 0);
        check("a_end_valid", tone_valid, 0);
        check("a_end_addr", mem_addr, 3);
        check("a_count", note_count, 3);

        // Ready held low for 10 cycles, then looping playback.
        tone_ready = 1'b0; loop_en = 1'b1;
        hb = hs_q.size();
        press_play();
        k = 0;
        while (!tone_valid && k < 20) begin tick(); k++; end
        check("b_valid_seen", tone_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("b_valid_stall", tone_valid, 1);
            check("b_note_stall", tone_note, 3);
            tick();
        end
        check("b_no_hs_while_stalled", hs_q.size() - hb, 0);
        tone_ready = 1'b1;
        wait_hs(hb + 5, 300);
        if (hs_q.size() >= hb + 5) begin
            for (int i = 0; i < 5; i++) check("b_loop_note", hs_q[hb+i], exp_seq[i]);
            check("b_gap_after_ready", hs_t[hb+1] - hs_t[hb], TICKS + 3);
        end
        stop_n = 1'b0;
        tick();
        check("b_stop_playing", playing, 0);
        check("b_stop_note", tone_note, 0);
        stop_n = 1'b1; loop_en = 1'b0;
        tick();

        // Stop during the hold of the second note.
        hb = hs_q.size();
        press_play();
        wait_hs(hb + 2, 100);
        tick();
        stop_n = 1'b0;
        tick();
        check("c_stop_playing", playing, 0);
        check("c_stop_note", tone_note, 0);
        check("c_stop_valid", tone_valid, 0);
        stop_n = 1'b1;
        repeat (8) tick();
        check("c_no_more_hs", hs_q.size() - hb, 2);
        check("c_count", note_count, 3);

        // Load and playback pressed in the same cycle: load wins.
        base = wr_addr_q.size();
        note_in = 5'd11; load_n = 1'b0; playback_n = 1'b0;
        tick();
        check("d_we", mem_we, 1);
        check("d_addr", mem_addr, 3);
        check("d_data", mem_wdata, 11);
        load_n = 1'b1; playback_n = 1'b1;
        repeat (4) tick();
        check("d_no_play", playing, 0);
        check("d_count", note_count, 4);
        check("d_writes", wr_addr_q.size() - base, 1);

        // Asynchronous reset mid-hold, then a key held low across release.
        hb = hs_q.size();
        press_play();
        wait_hs(hb + 1, 50);
        tick();
        #2 reset = 1'b0;
        #1;
        check("f_note", tone_note, 0);
        check("f_valid", tone_valid, 0);
        check("f_playing", playing, 0);
        check("f_we", mem_we, 0);
        check("f_count", note_count, 0);
        check("f_addr", mem_addr, 0);
        base = wr_addr_q.size();
        load_n = 1'b0;
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("f_held_key_writes", wr_addr_q.size() - base, 0);
        check("f_held_key_count", note_count, 0);
        load_n = 1'b1;
        tick();
        press_load(5'd21);
        check("f_repress_writes", wr_addr_q.size() - base, 1);
        check("f_repress_count", note_count, 1);

        // Fill past capacity: sixteen writes, seventeenth ignored.
        apply_loads(3, 19);

        // Randomized operations against a list-of-notes model.
        do_reset();
        m_notes.delete();
        for (int op = 0; op < 40; op++) begin
            if ($urandom_range(0, 9) < 6) begin
                logic [NW-1:0] n;
                n = NW'($urandom_range(0, 31));
                base = wr_addr_q.size();
                press_load(n);
                if (m_notes.size() < 16) begin
                    check("r_ld_writes", wr_addr_q.size() - base, 1);
                    if (wr_addr_q.size() > base) begin
                        check("r_ld_addr", wr_addr_q[base], m_notes.size());
                        check("r_ld_data", wr_data_q[base], n);
                    end
                    m_notes.push_back(n);
                end else begin
                    check("r_ld_full_writes", wr_addr_q.size() - base, 0);
                end
            end else begin
                hb = hs_q.size();
                press_play();
                wait_idle(3000, 1'b1);
                check("r_hs_count", hs_q.size() - hb, m_notes.size());
                if (hs_q.size() - hb == m_notes.size())
                    for (int i = 0; i < m_notes.size(); i++)
                        check("r_hs_note", hs_q[hb+i], m_notes[i]);
                check("r_end_note", tone_note, 0);
            end
            check("r_count", note_count, m_notes.size());
        end

        check("invariants", inv_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICKS_PER_NOTE, default 25000000, sets the hold time per note in clk cycles (0.5 s at 50 MHz); legal range 2..2^25-1.
REQ-002 Parameter NOTE_W, default 5, sets the note code width.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 load_n  in  1  active-low record request; falling edge records note_in.
REQ-006 playback_n  in  1  active-low play request; falling edge starts playback.
REQ-007 stop_n  in  1  active-low level abort of playback.
REQ-008 loop_en  in  1  1 = restart from index 0 after the last note.
REQ-009 note_in  in  NOTE_W  note code to record.
REQ-010 mem_we, mem_addr[3:0], mem_wdata[NOTE_W-1:0]  out  write strobe, address and data to the 16-entry note RAM.
REQ-011 mem_rdata  in  NOTE_W  RAM read data, valid exactly one cycle after mem_addr is presented.
REQ-012 tone_note  out  NOTE_W  note code to the tone generator; 0 = rest.
REQ-013 tone_valid  out  1 / tone_ready  in  1  valid/ready handshake to the tone generator.
REQ-014 note_count  out  5  number of stored notes, 0..16.
REQ-015 playing  out  1  high in every playback state.

Function
REQ-016 load_n and playback_n SHALL be edge-detected against their own value registered on the previous cycle; an edge is a 1 -> 0 change.
REQ-017 The FSM SHALL have the states IDLE, WRITE, FETCH, WAIT_RD, PRESENT and HOLD.
REQ-018 IDLE + load edge + note_count<16 -> WRITE; WRITE drives mem_we=1, mem_addr=note_count[3:0] and mem_wdata=note_in (sampled at the edge) for one cycle, increments note_count, then returns to IDLE.
REQ-019 A load edge with note_count==16, or in any state other than IDLE, SHALL be ignored with no write and no count change.
REQ-020 IDLE + playback edge + note_count>0 -> FETCH with play index 0; a playback edge with note_count==0 SHALL be ignored.
REQ-021 Load and playback edges in the same IDLE cycle: load wins and playback is dropped.
REQ-022 FETCH drives mem_addr=index for one cycle -> WAIT_RD.
REQ-023 WAIT_RD latches mem_rdata into tone_note -> PRESENT.
REQ-024 PRESENT holds tone_valid=1 with tone_note stable until the cycle tone_ready=1; that cycle completes the transfer and the FSM enters HOLD with the hold counter loaded to TICKS_PER_NOTE-1.
REQ-025 HOLD decrements the counter each cycle, and at 0:
- if index < note_count-1: index+1, then FETCH;
- else if loop_en: index 0, then FETCH;
- else tone_note<=0, then IDLE.
REQ-026 loop_en SHALL be sampled only at the HOLD expiry of the last note.
REQ-027 stop_n==0 in FETCH, WAIT_RD, PRESENT or HOLD SHALL force IDLE on the next edge, clear tone_note to 0 and deassert tone_valid; stop has priority over every other transition.
REQ-028 The play index SHALL be 4 bits and never exceed note_count-1.
REQ-029 The hold counter SHALL be 25 bits.
REQ-030 mem_we SHALL be 0 outside WRITE.
REQ-031 mem_addr SHALL be note_count[3:0] in IDLE/WRITE and the play index in the playback states.
REQ-032 tone_valid SHALL be 1 only in PRESENT.
REQ-033 playing SHALL be 1 exactly in FETCH, WAIT_RD, PRESENT and HOLD.
REQ-034 note_count SHALL be unchanged by playback; stored notes persist until reset.

Reset
REQ-035 reset==0 SHALL immediately, without waiting for clk, force: state IDLE, note_count 0, index 0, hold counter 0, tone_note 0, tone_valid 0, mem_we 0, playing 0, and both edge-detect registers to 1.
REQ-036 Reset asserted mid-playback or mid-write SHALL abort with no further mem_we pulse; RAM contents are outside this block.
REQ-037 After reset deassertion, a key held low SHALL NOT produce an edge until it is released and pressed again.

Verification (TICKS_PER_NOTE=4 in simulation)
REQ-038 Three load edges with note_in = 3, 7, 9 -> three single-cycle mem_we pulses at addresses 0, 1, 2 with matching data; note_count = 3.
REQ-039 Seventeen load edges -> sixteen writes, addresses 0..15; seventeenth ignored; note_count = 16.
REQ-040 Three notes stored, tone_ready tied 1, loop_en=0, playback edge -> tone_note sequence 3, 7, 9, each held 4 cycles after its handshake, then tone_note = 0, playing = 0, state IDLE.
REQ-041 Same setup, tone_ready held 0 for 10 cycles -> tone_valid=1 and tone_note=3 stable for all 10 cycles, HOLD starts after the ready cycle; with loop_en=1 the sequence restarts at 3 after 9.
REQ-042 stop_n pulled low during HOLD of note 2 -> IDLE next cycle, tone_note = 0; a load and playback edge in the same cycle -> write only, no playback.
REQ-043 reset asserted mid-HOLD, between clk edges -> all outputs at reset values before the next clk edge; note_count = 0.
